// File: rtl/floppy_pkg.sv
// Shared definitions for the floppy head control blocks.
//   seek_state_e  : seek/recalibrate sequencer states
//   DIR_OUT/DIR_IN: encodings of the stepper direction line
//   DEF_*         : default track geometry
package floppy_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStepHi,
    StStepLo,
    StSettle,
    StDone
  } seek_state_e;

  localparam logic DIR_OUT = 1'b1;  // toward cylinder 0
  localparam logic DIR_IN  = 1'b0;

  localparam int unsigned DEF_MAX_TRACK = 79;
  localparam int unsigned DEF_TRACK_W   = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous sensor inputs.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   i_d : asynchronous input
//   o_q : synchronized output (2 cycles latency)
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/head_seek_ctrl.sv
// Seek / recalibrate sequencer for the floppy head stepper.
//   clk, rst        : clock, asynchronous active-high reset
//   i_cmd_valid     : command request, taken when o_cmd_ready is high
//   o_cmd_ready     : high only while idle
//   i_cmd_recal     : 1 = recalibrate, 0 = seek to i_cmd_track
//   i_cmd_track     : seek target cylinder
//   i_tr0           : raw asynchronous track-0 sensor
//   o_step, o_dir   : step pulse and direction to the coil driver
//   o_busy, o_done  : command in progress / one-cycle completion pulse
//   o_err           : failure flag, valid with o_done, held until next accept
//   o_cur_track     : believed head cylinder
//   o_track_valid   : o_cur_track is trustworthy
module head_seek_ctrl
  import floppy_pkg::*;
#(
  parameter int unsigned MAX_TRACK   = DEF_MAX_TRACK,
  parameter int unsigned TRACK_W     = DEF_TRACK_W,
  parameter int unsigned STEP_PERIOD = 36000,
  parameter int unsigned STEP_PW     = 1200,
  parameter int unsigned DIR_SETUP   = 12,
  parameter int unsigned SETTLE      = 180000,
  parameter int unsigned RECAL_LIMIT = 84
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_recal,
  input  logic [TRACK_W-1:0] i_cmd_track,
  input  logic               i_tr0,
  output logic               o_step,
  output logic               o_dir,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [TRACK_W-1:0] o_cur_track,
  output logic               o_track_valid
);

  localparam int unsigned CNT_MAX = (STEP_PERIOD > SETTLE) ? STEP_PERIOD : SETTLE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STEPS_W = $clog2(RECAL_LIMIT + 1);

  localparam logic [CNT_W-1:0]   LD_SETUP  = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0]   LD_HI     = CNT_W'(STEP_PW - 1);
  localparam logic [CNT_W-1:0]   LD_LO     = CNT_W'(STEP_PERIOD - STEP_PW - 1);
  localparam logic [CNT_W-1:0]   LD_SETTLE = CNT_W'(SETTLE - 1);
  localparam logic [STEPS_W-1:0] LP_RLIM   = STEPS_W'(RECAL_LIMIT);
  localparam logic [TRACK_W-1:0] LP_MAX    = TRACK_W'(MAX_TRACK);

  seek_state_e        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [STEPS_W-1:0] r_steps;     // recalibrate steps issued
  logic [TRACK_W-1:0] r_target;
  logic               r_recal;     // command was an explicit recalibrate
  logic               r_recal_ph;  // currently in the recalibrate phase
  logic               r_step;
  logic               r_dir;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [TRACK_W-1:0] r_cur;
  logic               r_valid;

  logic               w_tr0_s;
  logic               w_slot;
  logic [TRACK_W-1:0] w_cur_dec;
  logic [TRACK_W-1:0] w_cur_inc;

  sync_2ff #(
    .WIDTH (1)
  ) u_tr0_sync (
    .clk (clk),
    .rst (rst),
    .i_d (i_tr0),
    .o_q (w_tr0_s)
  );

  // Step slot: the last cycle before a step would rise.
  assign w_slot    = ((r_state == StSetup) || (r_state == StStepLo)) && (r_cnt == '0);
  assign w_cur_dec = (r_cur == '0) ? r_cur : r_cur - TRACK_W'(1);
  assign w_cur_inc = (r_cur >= LP_MAX) ? r_cur : r_cur + TRACK_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_steps    <= '0;
      r_target   <= '0;
      r_recal    <= 1'b0;
      r_recal_ph <= 1'b0;
      r_step     <= 1'b0;
      r_dir      <= DIR_IN;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cur      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_slot) begin
        if (r_recal_ph) begin
          if (w_tr0_s) begin
            r_cur   <= '0;
            r_valid <= 1'b1;
            if (!r_recal && (r_target != '0)) begin
              // Implicit recalibrate finished: start the seek with a fresh setup.
              r_recal_ph <= 1'b0;
              r_dir      <= DIR_IN;
              r_state    <= StSetup;
              r_cnt      <= LD_SETUP;
            end else if (r_steps == '0) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= StSettle;
              r_cnt   <= LD_SETTLE;
            end
          end else if (r_steps == LP_RLIM) begin
            r_err   <= 1'b1;
            r_valid <= 1'b0;
            r_state <= StSettle;
            r_cnt   <= LD_SETTLE;
          end else begin
            r_step  <= 1'b1;
            r_state <= StStepHi;
            r_cnt   <= LD_HI;
            r_steps <= r_steps + STEPS_W'(1);
            r_cur   <= w_cur_dec;
          end
        end else if (r_cur == r_target) begin
          r_state <= StSettle;
          r_cnt   <= LD_SETTLE;
        end else if ((r_dir == DIR_OUT) && w_tr0_s) begin
          // Sensor says cylinder 0 but we believe otherwise: position is lost.
          r_cur   <= '0;
          r_valid <= 1'b0;
          r_err   <= 1'b1;
          r_state <= StDone;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_step  <= 1'b1;
          r_state <= StStepHi;
          r_cnt   <= LD_HI;
          r_cur   <= (r_dir == DIR_OUT) ? w_cur_dec : w_cur_inc;
        end
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_cmd_valid) begin
              r_target <= i_cmd_track;
              r_recal  <= i_cmd_recal;
              r_err    <= 1'b0;
              r_steps  <= '0;
              r_busy   <= 1'b1;
              if (!i_cmd_recal && (i_cmd_track > LP_MAX)) begin
                r_err   <= 1'b1;
                r_state <= StDone;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (i_cmd_recal && w_tr0_s) begin
                r_cur   <= '0;
                r_valid <= 1'b1;
                r_state <= StDone;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (i_cmd_recal || !r_valid) begin
                r_recal_ph <= 1'b1;
                r_dir      <= DIR_OUT;
                r_state    <= StSetup;
                r_cnt      <= LD_SETUP;
              end else if (i_cmd_track == r_cur) begin
                r_state <= StDone;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_recal_ph <= 1'b0;
                r_dir      <= (i_cmd_track < r_cur) ? DIR_OUT : DIR_IN;
                r_state    <= StSetup;
                r_cnt      <= LD_SETUP;
              end
            end
          end
          StSetup, StStepLo: r_cnt <= r_cnt - CNT_W'(1);
          StStepHi: begin
            if (r_cnt == '0) begin
              r_step  <= 1'b0;
              r_state <= StStepLo;
              r_cnt   <= LD_LO;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          StSettle: begin
            if (r_cnt == '0) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          StDone:  r_state <= StIdle;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_cmd_ready   = (r_state == StIdle);
  assign o_step        = r_step;
  assign o_dir         = r_dir;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_cur_track   = r_cur;
  assign o_track_valid = r_valid;

endmodule

// File: tb/tb_head_seek_ctrl.sv
// Scoreboard bench for head_seek_ctrl: the driver pushes the expected outcome of each
// command, a negedge monitor checks step pulses as they occur and pops/compares on done.
module tb_head_seek_ctrl;

  localparam int unsigned SP  = 8;
  localparam int unsigned PW  = 3;
  localparam int unsigned DS  = 2;
  localparam int unsigned STL = 5;
  localparam int unsigned RL  = 6;

  typedef struct {
    int err;
    int cur;
    int valid;
    int steps;
    int lat;    // done cycle relative to accept cycle
    int first;  // first step rise relative to accept, 0 = unchecked
    int dir;    // dir during every step, 2 = unchecked
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_recal = 1'b0;
  logic [6:0] cmd_track = '0;
  logic       tr0 = 1'b0;
  logic       cmd_ready, step, dir, busy, done, err, track_valid;
  logic [6:0] cur_track;

  head_seek_ctrl #(
    .MAX_TRACK   (79),
    .TRACK_W     (7),
    .STEP_PERIOD (SP),
    .STEP_PW     (PW),
    .DIR_SETUP   (DS),
    .SETTLE      (STL),
    .RECAL_LIMIT (RL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_recal   (cmd_recal),
    .i_cmd_track   (cmd_track),
    .i_tr0         (tr0),
    .o_step        (step),
    .o_dir         (dir),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_cur_track   (cur_track),
    .o_track_valid (track_valid)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   acc_cyc = -1000;
  int   nsteps = 0;
  int   last_rise = -1;
  int   hi_cnt = 0;
  int   n_done = 0;
  logic prev_step = 1'b0;
  exp_t sb[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int e, input int c, input int v, input int s,
                              input int l, input int f, input int d);
    exp_t x;
    x.err = e; x.cur = c; x.valid = v; x.steps = s; x.lat = l; x.first = f; x.dir = d;
    return x;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_step = 1'b0;
      hi_cnt    = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc   = cyc;
        nsteps    = 0;
        last_rise = -1;
      end
      if (sb.size() > 0) begin
        e = sb[0];
        if (cyc == acc_cyc + 1 && e.lat > 1) check("busy_after_accept", int'(busy), 1);
        if (step && !prev_step) begin
          nsteps = nsteps + 1;
          if (nsteps == 1 && e.first != 0) check("first_step_time", cyc - acc_cyc, e.first);
          if (e.dir != 2) begin
            check("step_dir", int'(dir), e.dir);
            if (last_rise >= 0) check("step_period", cyc - last_rise, SP);
          end
          last_rise = cyc;
        end
      end
      if (step) hi_cnt = hi_cnt + 1;
      if (!step && prev_step) begin
        check("step_width", hi_cnt, PW);
        hi_cnt = 0;
      end
      prev_step = step;
      if (done) begin
        n_done = n_done + 1;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc - acc_cyc, e.lat);
          check("err", int'(err), e.err);
          check("cur_track", int'(cur_track), e.cur);
          check("track_valid", int'(track_valid), e.valid);
          check("step_count", nsteps, e.steps);
          check("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic send(input logic recal, input int trk, input exp_t e);
    int k;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_recal = recal;
    cmd_track = 7'(trk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 200);
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int k;
    start = n_done;
    k = 0;
    while (n_done == start && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (n_done == start) begin
      check("done_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_steps(input int n, input int budget);
    int k;
    k = 0;
    while (nsteps < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (nsteps < n) check("step_wait_timeout", nsteps, n);
  endtask

  task automatic set_tr0(input logic v);
    @(posedge clk);
    #1;
    tr0 = v;
    repeat (4) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_step"}, int'(step), 0);
    check({tag, "_dir"}, int'(dir), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_cur_track"}, int'(cur_track), 0);
    check({tag, "_track_valid"}, int'(track_valid), 0);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    rst = 1'b1;
    tr0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    repeat (4) @(posedge clk);

    // Recalibrate already at cylinder 0: no steps, immediate done.
    send(1'b1, 0, mk(0, 0, 1, 0, 1, 0, 2));
    wait_done(50);
    set_tr0(1'b0);
    // Seek 0 -> 5: 1+2+5*8+5 = 48.
    send(1'b0, 5, mk(0, 5, 1, 5, 48, 3, 0));
    wait_done(100);
    // Seek to current track.
    send(1'b0, 5, mk(0, 5, 1, 0, 1, 0, 2));
    wait_done(20);
    // Out-of-range target.
    send(1'b0, 80, mk(1, 5, 1, 0, 1, 0, 2));
    wait_done(20);
    // Seek 5 -> 2 outward: 1+2+3*8+5 = 32.
    send(1'b0, 2, mk(0, 2, 1, 3, 32, 3, 1));
    wait_done(100);
    // Recalibrate, sensor rises after the third step.
    send(1'b1, 0, mk(0, 0, 1, 3, 32, 3, 1));
    wait_steps(3, 100);
    #1 tr0 = 1'b1;
    wait_done(100);
    set_tr0(1'b0);
    // Recalibrate with sensor stuck low: 1+2+6*8+5 = 56.
    send(1'b1, 0, mk(1, 0, 0, 6, 56, 3, 1));
    wait_done(150);
    // Seek to 3 with track invalid: 2 recal steps, then 3 seek steps, done at +50.
    send(1'b0, 3, mk(0, 3, 1, 5, 50, 3, 2));
    wait_steps(2, 100);
    #1 tr0 = 1'b1;
    wait_done(150);
    // Outward seek sees track-0 while believing cylinder 3: error at first slot.
    send(1'b0, 1, mk(1, 0, 0, 0, 3, 0, 2));
    wait_done(20);
    set_tr0(1'b0);

    // Reset while a step is high: command abandoned, no done.
    send(1'b1, 0, mk(1, 0, 0, 6, 56, 3, 1));
    wait_steps(1, 50);
    #2;
    check("step_high_before_reset", int'(step), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    saved = n_done;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check("cmd_ready_after_reset", int'(cmd_ready), 1);
    repeat (20) @(posedge clk);
    check("no_done_after_reset", n_done, saved);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/head_seek_ctrl.md
# head_seek_ctrl

Seek and recalibrate sequencer for the floppy head stepper. It accepts one seek or recalibrate command at a time and generates paced, direction-qualified step pulses for the debounced stepper coil driver. It watches the synchronized track-0 sensor and tracks the current head cylinder. It sits between the host-side command logic and the `step`/`dir`/`tr0` inputs of the coil driver.

## Interface
- `MAX_TRACK`, 79: highest legal cylinder.
- `TRACK_W`, 7: width of track fields.
- `STEP_PERIOD`, 36000: clocks between step rising edges (3 ms at 12 MHz).
- `STEP_PW`, 1200: step high time in clocks; must exceed the coil driver's debounce window.
- `DIR_SETUP`, 12: clocks from `dir` valid to the first step rising edge.
- `SETTLE`, 180000: head settle clocks after the last step period.
- `RECAL_LIMIT`, 84: maximum outward steps before recalibrate fails.
- `clk  in  1`: system clock. This is the single clock.
- `rst  in  1`: asynchronous, active-high reset.
- `cmd_valid  in  1`: command request.
- `cmd_ready  out  1`: high only in IDLE.
- `cmd_recal  in  1`: 1 selects recalibrate; 0 selects seek to `cmd_track`.
- `cmd_track  in  TRACK_W`: target cylinder for a seek.
- `tr0  in  1`: raw track-0 sensor, high at cylinder 0. Asynchronous.
- `step  out  1`: step pulse to the coil driver, active high.
- `dir  out  1`: 1 means outward (toward cylinder 0); 0 means inward.
- `busy  out  1`: high from command accept until `done`.
- `done  out  1`: one-cycle completion pulse.
- `err  out  1`: failure flag, valid with `done`; held until the next accept.
- `cur_track  out  TRACK_W`: believed head cylinder.
- `track_valid  out  1`: `cur_track` is trustworthy.

## Operation
- `tr0` passes through a 2-flop synchronizer, giving `tr0_s`. All decisions use `tr0_s`.
- **Accept:** a command is accepted when `cmd_valid & cmd_ready`. `cmd_track` and `cmd_recal` are registered on accept.
- **States:** IDLE, SETUP, STEP_HI, STEP_LO, SETTLE, DONE.
- **Seek with target > `MAX_TRACK`:** no motion. Go straight to DONE with `err`=1; `cur_track` is unchanged.
- **Seek with `track_valid`=0:** perform an implicit recalibrate first, then seek. A single `done` pulse is issued at the end.
- **Seek with target == `cur_track`:** no steps and no settle. `done` pulses 1 cycle after accept.
- **Seek direction:** `dir` = (target < `cur_track`). Number of steps = |target − `cur_track`|.
- **Track update:** `cur_track` changes by ±1 on each step rising edge.
- **Recalibrate:** `dir`=1. `tr0_s` is sampled at each step slot (the cycle the step would rise).
  - If `tr0_s`=1: stop, set `cur_track`=0 and `track_valid`=1. Zero steps are issued if already at cylinder 0.
  - If `RECAL_LIMIT` steps are issued without seeing `tr0_s`: `err`=1 and `track_valid`=0.
- **Outward seek consistency:** if `tr0_s`=1 at a step slot while `cur_track`≠0, the step is suppressed. Then `cur_track`←0, `track_valid`←0, `err`=1, and go to DONE without settle.
- **Stability:** `dir` is held stable for the whole command. `cmd_valid` is ignored while `busy`.

## Timing
- **Reset values:** `step`=0, `dir`=0, `busy`=0, `done`=0, `err`=0, `cur_track`=0, `track_valid`=0, `cmd_ready`=1. The state is IDLE and the synchronizer flops are cleared.
- **Reset mid-operation:** `step` drops asynchronously and the command is abandoned. No `done` is issued.
- **Accept cycle t0:** `dir` and `busy` become valid at t0+1.
- **Step k (k=0..N−1):** rises at t0+1+`DIR_SETUP`+k·`STEP_PERIOD` and stays high for `STEP_PW` cycles.
- **Completion:** SETTLE starts at t0+1+`DIR_SETUP`+N·`STEP_PERIOD` and lasts `SETTLE` cycles. `done` pulses in the next cycle and `busy` falls with it. `cmd_ready` rises the cycle after `done`.
- **Implicit recalibrate:** the recalibrate phase has no settle. The seek phase begins with its own `DIR_SETUP`.
- **Counters:** width is $clog2(max(`STEP_PERIOD`,`SETTLE`)+1). Step count width is $clog2(`RECAL_LIMIT`+1). No wrap: `cur_track` never decrements below 0 or increments past `MAX_TRACK`.

## Structure
- **Package `floppy_pkg`:** state enum, `DIR_OUT`/`DIR_IN` encodings, and `MAX_TRACK`/`TRACK_W` defaults.
- **Sub-module `sync_2ff`:** synchronizer for `tr0`, reusable for the other sensor inputs.
- **Remaining logic:** one FSM, one shared interval counter (setup, step period, and settle) and one step counter.

## Test plan
Parameters for the bench: `STEP_PERIOD`=8, `STEP_PW`=3, `DIR_SETUP`=2, `SETTLE`=5, `RECAL_LIMIT`=6.
- **Reset, then recal with `tr0`=1:** no steps; `done` at t0+1 (+sync latency); `cur_track`=0, `track_valid`=1, `err`=0.
- **Recal with `tr0` rising after the 3rd step:** 3 steps with `dir`=1 at t0+3, +11, +19; `cur_track`=0, `track_valid`=1.
- **Seek 0→5:** 5 inward pulses, 3 cycles high each; `cur_track`=5; `done` at t0+1+2+40+5.
- **Seek when `track_valid`=0:** implicit recal, then seek; exactly one `done`. Seek to 80: immediate `err` with no steps.
- **Recal with `tr0` stuck low:** 6 steps, then `err`=1 and `track_valid`=0.
- **Assert `rst` during `step` high:** `step`=0 immediately; all outputs at reset values; `cmd_ready`=1 after release.
